// File: rtl/p_dec_pkg.sv
// Shared widths, defaults and state codes for the p_dec grant decoder.
// Pure definitions: no latency and no backpressure of its own.
package p_dec_pkg;
   localparam int CODE_W   = 2;
   localparam int GNT_W    = 4;
   localparam int CNT_W    = 5;
   localparam int HOLD_DEF = 4;
   localparam int GAP_DEF  = 1;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_GRANT = 2'd1;
   localparam state_t ST_GAP   = 2'd2;

   function automatic logic [GNT_W-1:0] onehot(input logic [CODE_W-1:0] idx);
      return GNT_W'(1) << idx;
   endfunction
endpackage

// File: rtl/p_dec_cnt.sv
// Down-counter with synchronous load, decrement-while-nonzero and a zero flag.
// Load/decrement take effect on the next edge; it has no backpressure.
module p_dec_cnt
   import p_dec_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             dec,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (dec && cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);
endmodule

// File: rtl/p_dec.sv
// Request decoder: latches index y and drives a one-hot grant g for HOLD cycles, then GAP idle cycles.
// Latency: g rises one cycle after the accepting edge. Requests while rdy=0 are dropped, not queued.
// Optional P_DEC_EXTEND_EN: a matching request during a grant reloads the hold time.
module p_dec
   import p_dec_pkg::*;
#(
   parameter int HOLD = HOLD_DEF,
   parameter int GAP  = GAP_DEF
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [CODE_W-1:0] y,
   input  logic              v,
   output logic              rdy,
   output logic [GNT_W-1:0]  g,
   output logic              busy,
   output logic              done
);
   localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD - 1);
   localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'((GAP > 0) ? GAP - 1 : 0);

   state_t            state, state_nxt;
   logic [CODE_W-1:0] y_lat, y_lat_nxt;
   logic [GNT_W-1:0]  g_nxt;
   logic              done_nxt;
   logic              cnt_load, cnt_dec, cnt_zero;
   logic [CNT_W-1:0]  cnt_ld_val;

   p_dec_cnt u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .dec      (cnt_dec),
      .load_val (cnt_ld_val),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_nxt  = state;
      y_lat_nxt  = y_lat;
      g_nxt      = '0;
      done_nxt   = 1'b0;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;
      cnt_ld_val = HOLD_LD;
      case (state)
         ST_IDLE: begin
            if (v) begin
               y_lat_nxt = y;
               g_nxt     = onehot(y);
               cnt_load  = 1'b1;
               state_nxt = ST_GRANT;
            end
         end
         ST_GRANT: begin
            g_nxt = onehot(y_lat);
`ifdef P_DEC_EXTEND_EN
            if (v && y == y_lat) begin
               cnt_load = 1'b1;
            end else
`endif
            if (cnt_zero) begin
               // Last grant cycle: drop g and pulse done on the same edge.
               g_nxt    = '0;
               done_nxt = 1'b1;
               if (GAP > 0) begin
                  cnt_load   = 1'b1;
                  cnt_ld_val = GAP_LD;
                  state_nxt  = ST_GAP;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_GAP: begin
            if (cnt_zero)
               state_nxt = ST_IDLE;
            else
               cnt_dec = 1'b1;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         y_lat <= '0;
         g     <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         y_lat <= y_lat_nxt;
         g     <= g_nxt;
         done  <= done_nxt;
      end
   end

   assign rdy  = (state == ST_IDLE);
   assign busy = (state == ST_GRANT) || (state == ST_GAP);
endmodule

// File: doc/p_dec.md
P_DEC -- requirements
Module: p_dec

Interface
REQ-001 Parameter HOLD, default 4, number of cycles a grant stays asserted; legal range 1..16.
REQ-002 Parameter GAP, default 1, number of idle cycles forced after a grant; legal range 0..15.
REQ-003 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, asynchronous, active-high reset.
REQ-005 Port y, input, 2, encoded request index (3 = highest-priority line).
REQ-006 Port v, input, 1, request valid; y is meaningful only while v=1.
REQ-007 Port rdy, output, 1, block accepts a request this cycle.
REQ-008 Port g, output, 4, registered one-hot grant, g[i] for index i.
REQ-009 Port busy, output, 1, high in GRANT or GAP.
REQ-010 Port done, output, 1, one-cycle pulse when a grant ends.

Function
REQ-011 The block SHALL implement three states: IDLE, GRANT and GAP.
REQ-012 IDLE: rdy=1, g=0000, busy=0; a request is accepted on a rising edge with v=1.
REQ-013 On acceptance, the block SHALL latch y, load the hold counter with HOLD-1 and enter GRANT.
REQ-014 g SHALL equal 1<<y_latched from the cycle after the acceptance edge; latency is one cycle.
REQ-015 GRANT: rdy=0, busy=1; the counter decrements each cycle while nonzero.
REQ-016 GRANT exit, counter 0 at the edge: g cleared, done=1 for one cycle, next state GAP if GAP>0 else IDLE.
REQ-017 GAP: g=0000, rdy=0, busy=1; the block SHALL stay GAP cycles, then enter IDLE.
REQ-018 A request with v=1 while rdy=0 SHALL be ignored, neither queued nor latched (except REQ-024).
REQ-019 HOLD=1 SHALL give exactly one grant cycle; GAP=0 with v held high SHALL give back-to-back grants separated by one IDLE cycle.
REQ-020 g SHALL never have more than one bit set; y changes while not in IDLE SHALL NOT affect g.

Reset
REQ-021 Asserting rst SHALL immediately force state=IDLE, g=0000, done=0, busy=0, rdy=1, counters=0, latched index=00, including mid-GRANT and mid-GAP.
REQ-022 The first acceptance after reset release SHALL occur on the first rising edge with rst=0 and v=1.

Configuration
REQ-023 Macro P_DEC_EXTEND_EN SHALL select grant extension at compile time.
REQ-024 When P_DEC_EXTEND_EN is defined: in GRANT, v=1 with y equal to the latched index SHALL reload the counter to HOLD-1 with no done pulse; a different y is ignored.
REQ-025 When P_DEC_EXTEND_EN is undefined, all requests during GRANT SHALL be ignored and the grant length is exactly HOLD cycles.

Structure
REQ-026 Package p_dec_pkg SHALL hold the state enumeration, code width (2), grant width (4), counter width (5) and HOLD/GAP defaults.
REQ-027 The down-counter with load, decrement and zero flag SHALL be a sub-module p_dec_cnt, instantiated once and shared by GRANT and GAP.

Verification
REQ-028 Reset, then y=10, v=1 for one cycle -> g=0100 for 4 cycles starting one cycle later, done pulse, busy 5 cycles, then rdy=1.
REQ-029 Sweep y=00..11, one request each -> g=0001, 0010, 0100, 1000 respectively; never more than one bit set.
REQ-030 During GRANT for y=01, drive v=1 with y=11 -> g stays 0010, no second grant afterward.
REQ-031 Assert rst in the 2nd grant cycle -> g=0000 and rdy=1 with no clock edge; no done pulse.
REQ-032 HOLD=1, GAP=0, v held 1 with y=11 -> g=1000 pulses one cycle high, one cycle low, repeating.
REQ-033 With P_DEC_EXTEND_EN, y=00 re-presented in each grant cycle for 6 cycles -> g=0001 held 6+HOLD-1 cycles, one done at end.
